deal_sequencer: RTL

//  Dealer control stage directly upstream of the card-push motor block. Per hand it deals

---
 rtl/deal_sequencer_if.sv | 32 +++
 rtl/deal_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/deal_sequencer_if.sv
// ---------------------------------------------------------------------------
// deal_sequencer_if
//   Control/status bundle between the dealing controller and its environment
//   (hand start/abort, table rotator handshake, motor-block drive, status).
//   master : environment side (drives start/abort/config/rot_done)
//   slave  : deal_sequencer side (drives motor, rotator request and status)
// ---------------------------------------------------------------------------
interface deal_sequencer_if;
    logic       start;
    logic       abort;
    logic [2:0] num_players;
    logic [3:0] cards_per_player;
    logic       rot_done;
    logic [1:0] motor_state;
    logic       en;
    logic       rot_req;
    logic       rot_home;
    logic [2:0] player_idx;
    logic [6:0] cards_left;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, num_players, cards_per_player, rot_done,
        input  motor_state, en, rot_req, rot_home, player_idx, cards_left, busy, done
    );

    modport slave (
        input  start, abort, num_players, cards_per_player, rot_done,
        output motor_state, en, rot_req, rot_home, player_idx, cards_left, busy, done
    );
endinterface

// File: rtl/deal_sequencer.sv
// ---------------------------------------------------------------------------
// deal_sequencer
//   Deals one hand round-robin: push a card (motor WAIT + en), settle
//   (motor REMAIN), rotate the table one seat, repeat; after the last card
//   the table is sent home and done pulses for one cycle.
// Ports
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : deal_sequencer_if.slave
//          in : start, abort, num_players[2:0], cards_per_player[3:0], rot_done
//          out: motor_state[1:0], en, rot_req, rot_home, player_idx[2:0],
//               cards_left[6:0], busy, done
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module deal_sequencer #(
    parameter int PUSH_CYCLES   = 262144,
    parameter int SETTLE_CYCLES = 1000000,
    parameter int CNT_W         = 24
) (
    input  logic             clk,
    input  logic             rst,
    deal_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH, S_SETTLE, S_ROTATE, S_HOME, S_DONE
    } state_e;

    localparam logic [1:0] MS_RESET  = 2'b00;
    localparam logic [1:0] MS_ROTATE = 2'b01;
    localparam logic [1:0] MS_WAIT   = 2'b10;
    localparam logic [1:0] MS_REMAIN = 2'b11;

    localparam logic [CNT_W-1:0] PUSH_LAST   = CNT_W'(PUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [2:0]         np_q, np_d;
    logic [2:0]         player_q, player_d;
    logic [6:0]         cards_q, cards_d;

    logic [1:0]         motor_state_q, motor_state_d;
    logic               en_q, en_d;
    logic               rot_req_q, rot_req_d;
    logic               rot_home_q, rot_home_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            np_q          <= '0;
            player_q      <= '0;
            cards_q       <= '0;
            motor_state_q <= MS_RESET;
            en_q          <= 1'b0;
            rot_req_q     <= 1'b0;
            rot_home_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            np_q          <= np_d;
            player_q      <= player_d;
            cards_q       <= cards_d;
            motor_state_q <= motor_state_d;
            en_q          <= en_d;
            rot_req_q     <= rot_req_d;
            rot_home_q    <= rot_home_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 1'b1;
        np_d     = np_q;
        player_d = player_q;
        cards_d  = cards_q;

        if (bus.abort) begin
            state_d  = S_IDLE;
            timer_d  = '0;
            player_d = '0;
            cards_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    timer_d = '0;
                    // A hand with no players or no cards is not a hand.
                    if (bus.start && bus.num_players != 3'd0 && bus.cards_per_player != 4'd0) begin
                        np_d     = bus.num_players;
                        cards_d  = 7'(bus.num_players) * 7'(bus.cards_per_player);
                        player_d = '0;
                        state_d  = S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (timer_q == PUSH_LAST) begin
                        timer_d = '0;
                        cards_d = (cards_q != 7'd0) ? cards_q - 7'd1 : 7'd0;
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (timer_q == SETTLE_LAST) begin
                        timer_d = '0;
                        if (cards_q == 7'd0)   state_d = S_HOME;
                        else if (np_q == 3'd1) state_d = S_PUSH;   // single seat: never rotate
                        else                   state_d = S_ROTATE;
                    end
                end
                S_ROTATE: begin
                    timer_d = '0;
                    if (bus.rot_done) begin
                        player_d = (player_q == np_q - 3'd1) ? 3'd0 : player_q + 3'd1;
                        state_d  = S_PUSH;
                    end
                end
                S_HOME: begin
                    timer_d = '0;
                    if (bus.rot_done) begin
                        player_d = '0;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they land in flops
    // aligned with the state they describe.
    always_comb begin
        motor_state_d = MS_RESET;
        en_d          = 1'b0;
        rot_req_d     = 1'b0;
        rot_home_d    = 1'b0;
        busy_d        = 1'b1;
        done_d        = 1'b0;
        unique case (state_d)
            S_IDLE:   busy_d = 1'b0;
            S_PUSH: begin
                motor_state_d = MS_WAIT;
                en_d          = 1'b1;
            end
            S_SETTLE: motor_state_d = MS_REMAIN;
            S_ROTATE: begin
                motor_state_d = MS_ROTATE;
                rot_req_d     = 1'b1;
            end
            S_HOME: begin
                motor_state_d = MS_ROTATE;
                rot_req_d     = 1'b1;
                rot_home_d    = 1'b1;
            end
            S_DONE:   done_d = 1'b1;
            default:  busy_d = 1'b0;
        endcase
    end

    assign bus.motor_state = motor_state_q;
    assign bus.en          = en_q;
    assign bus.rot_req     = rot_req_q;
    assign bus.rot_home    = rot_home_q;
    assign bus.player_idx  = player_q;
    assign bus.cards_left  = cards_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
